// File: rtl/branch_resolve_if.sv
// Branch-resolve stage bus: decoded instruction fields and operands in,
// registered branch/jump resolution out.
interface branch_resolve_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic          stall_i;
   logic          flush_i;
   logic          valid_i;
   logic [5:0]    op;
   logic [5:0]    func;
   logic [4:0]    rt;
   logic [4:0]    rd;
   logic [15:0]   imm;
   logic [25:0]   instr_index;
   logic [AW-1:0] pc_i;
   logic [DW-1:0] rs_data;
   logic [DW-1:0] rt_data;

   logic          valid_o;
   logic          redirect_o;
   logic [AW-1:0] target_o;
   logic          link_we_o;
   logic [4:0]    link_reg_o;
   logic [DW-1:0] link_data_o;
   logic          in_delay_slot_o;
   logic          err_o;

   modport master (
      output stall_i, flush_i, valid_i, op, func, rt, rd, imm, instr_index,
             pc_i, rs_data, rt_data,
      input  valid_o, redirect_o, target_o, link_we_o, link_reg_o,
             link_data_o, in_delay_slot_o, err_o
   );

   modport slave (
      input  stall_i, flush_i, valid_i, op, func, rt, rd, imm, instr_index,
             pc_i, rs_data, rt_data,
      output valid_o, redirect_o, target_o, link_we_o, link_reg_o,
             link_data_o, in_delay_slot_o, err_o
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// MIPS branch/jump resolution: condition, target and link evaluated combinationally,
// registered for EX, with delay-slot tracking and a saturating taken-redirect counter.
module branch_resolve_unit #(
   parameter int DW         = 32,
   parameter int AW         = 32,
   parameter int DELAY_SLOT = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   branch_resolve_if.slave  bus,
   output logic [CNT_W-1:0] taken_cnt_o
);
   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] FN_JR     = 6'b001000;
   localparam logic [5:0] FN_JALR   = 6'b001001;
   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   typedef enum logic {NORM, SLOT} ds_state_e;

   ds_state_e state_q, state_d;

   // decode
   logic is_jr, is_jalr, is_j, is_jal, is_beq, is_bne, is_blez, is_bgtz;
   logic is_bltz, is_bgez, is_bltzal, is_bgezal, is_ctl;
   logic rs_neg, rs_zero, rs_eq_rt, taken;
   logic accept, in_slot;

   assign is_jr     = (bus.op == OP_RTYPE) && (bus.func == FN_JR);
   assign is_jalr   = (bus.op == OP_RTYPE) && (bus.func == FN_JALR);
   assign is_j      = (bus.op == OP_J);
   assign is_jal    = (bus.op == OP_JAL);
   assign is_beq    = (bus.op == OP_BEQ);
   assign is_bne    = (bus.op == OP_BNE);
   assign is_blez   = (bus.op == OP_BLEZ);
   assign is_bgtz   = (bus.op == OP_BGTZ);
   assign is_bltz   = (bus.op == OP_REGIMM) && (bus.rt == RT_BLTZ);
   assign is_bgez   = (bus.op == OP_REGIMM) && (bus.rt == RT_BGEZ);
   assign is_bltzal = (bus.op == OP_REGIMM) && (bus.rt == RT_BLTZAL);
   assign is_bgezal = (bus.op == OP_REGIMM) && (bus.rt == RT_BGEZAL);

   assign is_ctl = is_jr | is_jalr | is_j | is_jal | is_beq | is_bne | is_blez |
                   is_bgtz | is_bltz | is_bgez | is_bltzal | is_bgezal;

   // signed compares against zero reduce to sign bit and zero detect
   assign rs_neg   = bus.rs_data[DW-1];
   assign rs_zero  = (bus.rs_data == '0);
   assign rs_eq_rt = (bus.rs_data == bus.rt_data);

   assign taken = is_jr | is_jalr | is_j | is_jal
                | (is_beq & rs_eq_rt)
                | (is_bne & ~rs_eq_rt)
                | (is_blez & (rs_neg | rs_zero))
                | (is_bgtz & ~rs_neg & ~rs_zero)
                | ((is_bltz | is_bltzal) & rs_neg)
                | ((is_bgez | is_bgezal) & ~rs_neg);

   // targets and link
   logic [AW-1:0] pc4, pc8, br_tgt, j_tgt, rs_tgt, tgt;
   logic [DW-1:0] lnk_data;
   logic [4:0]    lnk_reg;
   logic          lnk_we;

   assign pc4      = bus.pc_i + AW'(4);
   assign pc8      = bus.pc_i + AW'(8);
   assign br_tgt   = pc4 + {{(AW-18){bus.imm[15]}}, bus.imm, 2'b00};
   assign rs_tgt   = AW'(bus.rs_data);
   assign lnk_data = DW'(pc8);

   always_comb begin
      j_tgt       = pc4;
      j_tgt[27:0] = {bus.instr_index, 2'b00};
   end

   always_comb begin
      tgt = br_tgt;
      if (is_jr || is_jalr)    tgt = rs_tgt;
      else if (is_j || is_jal) tgt = j_tgt;
   end

   always_comb begin
      lnk_reg = 5'd0;
      lnk_we  = 1'b0;
      if (is_jal || is_bltzal || is_bgezal) begin
         lnk_reg = 5'd31;
         lnk_we  = 1'b1;
      end else if (is_jalr) begin
         lnk_reg = bus.rd;
         lnk_we  = (bus.rd != 5'd0);
      end
   end

   // delay-slot FSM and next flag values
   logic nx_redirect, nx_lwe, nx_ds, nx_err;

   assign accept  = bus.valid_i & ~bus.stall_i & ~bus.flush_i;
   assign in_slot = (DELAY_SLOT != 0) && (state_q == SLOT);

   always_comb begin
      state_d     = state_q;
      nx_redirect = 1'b0;
      nx_lwe      = 1'b0;
      nx_ds       = 1'b0;
      nx_err      = 1'b0;
      if (accept) begin
         if (in_slot) begin
            // transfer inside a delay slot is reported, never executed
            nx_ds   = 1'b1;
            nx_err  = is_ctl;
            state_d = NORM;
         end else begin
            nx_redirect = is_ctl & taken;
            nx_lwe      = lnk_we;
            if (is_ctl && DELAY_SLOT != 0) state_d = SLOT;
         end
      end
      if (bus.flush_i) state_d = NORM;
   end

   always_ff @(posedge clk) begin
      if (!rst)                          state_q <= NORM;
      else if (bus.flush_i || !bus.stall_i) state_q <= state_d;
   end

   // output registers
   logic             vld_q, redirect_q, lwe_q, ds_q, err_q;
   logic [AW-1:0]    tgt_q;
   logic [4:0]       lreg_q;
   logic [DW-1:0]    ldata_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q      <= 1'b0;
         redirect_q <= 1'b0;
         lwe_q      <= 1'b0;
         ds_q       <= 1'b0;
         err_q      <= 1'b0;
         tgt_q      <= '0;
         lreg_q     <= '0;
         ldata_q    <= '0;
         cnt_q      <= '0;
      end else if (bus.flush_i) begin
         vld_q      <= 1'b0;
         redirect_q <= 1'b0;
         lwe_q      <= 1'b0;
         ds_q       <= 1'b0;
         err_q      <= 1'b0;
      end else if (!bus.stall_i) begin
         vld_q      <= accept;
         redirect_q <= nx_redirect;
         lwe_q      <= nx_lwe;
         ds_q       <= nx_ds;
         err_q      <= nx_err;
         if (accept) begin
            tgt_q   <= tgt;
            lreg_q  <= lnk_reg;
            ldata_q <= lnk_data;
         end
         // a held redirect is counted on the first unstalled edge only
         if (redirect_q && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.valid_o         = vld_q;
   assign bus.redirect_o      = redirect_q;
   assign bus.target_o        = tgt_q;
   assign bus.link_we_o       = lwe_q;
   assign bus.link_reg_o      = lreg_q;
   assign bus.link_data_o     = ldata_q;
   assign bus.in_delay_slot_o = ds_q;
   assign bus.err_o           = err_q;
   assign taken_cnt_o         = cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: three instances (delay slot on, delay slot off, 2-bit counter)
// driven by directed vectors; a negedge monitor pops expected records by cycle.
module tb_branch_resolve_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        v, st, fl;
      logic [5:0]  op, fn;
      logic [4:0]  rt, rd;
      logic [15:0] imm;
      logic [25:0] idx;
      logic [31:0] pc, rs, rtd;
   } stim_t;

   typedef struct {
      int          sel;
      int          cyc;
      string       tag;
      logic        v, r, lwe, ds, err, dchk;
      logic [31:0] tgt, ldata;
      logic [4:0]  lreg;
      logic [15:0] cnt;
   } exp_t;

   stim_t cur [3];
   exp_t  sb [$];

   branch_resolve_if #(.DW(32), .AW(32)) bus [3] ();

   logic        ov [3], ordr [3], olwe [3], ods [3], oerr [3];
   logic [31:0] otgt [3], oldata [3];
   logic [4:0]  olreg [3];
   logic [15:0] ocnt [3];
   logic [15:0] cnt0, cnt1;
   logic [1:0]  cnt2;

   for (genvar g = 0; g < 3; g++) begin : g_bus
      assign bus[g].stall_i     = cur[g].st;
      assign bus[g].flush_i     = cur[g].fl;
      assign bus[g].valid_i     = cur[g].v;
      assign bus[g].op          = cur[g].op;
      assign bus[g].func        = cur[g].fn;
      assign bus[g].rt          = cur[g].rt;
      assign bus[g].rd          = cur[g].rd;
      assign bus[g].imm         = cur[g].imm;
      assign bus[g].instr_index = cur[g].idx;
      assign bus[g].pc_i        = cur[g].pc;
      assign bus[g].rs_data     = cur[g].rs;
      assign bus[g].rt_data     = cur[g].rtd;
      assign ov[g]     = bus[g].valid_o;
      assign ordr[g]   = bus[g].redirect_o;
      assign olwe[g]   = bus[g].link_we_o;
      assign ods[g]    = bus[g].in_delay_slot_o;
      assign oerr[g]   = bus[g].err_o;
      assign otgt[g]   = bus[g].target_o;
      assign oldata[g] = bus[g].link_data_o;
      assign olreg[g]  = bus[g].link_reg_o;
   end
   assign ocnt[0] = cnt0;
   assign ocnt[1] = cnt1;
   assign ocnt[2] = {14'd0, cnt2};

   branch_resolve_unit #(.DW(32), .AW(32), .DELAY_SLOT(1), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .bus(bus[0]), .taken_cnt_o(cnt0));
   branch_resolve_unit #(.DW(32), .AW(32), .DELAY_SLOT(0), .CNT_W(16)) u_dut_nd (
      .clk(clk), .rst(rst), .bus(bus[1]), .taken_cnt_o(cnt1));
   branch_resolve_unit #(.DW(32), .AW(32), .DELAY_SLOT(0), .CNT_W(2)) u_dut_c2 (
      .clk(clk), .rst(rst), .bus(bus[2]), .taken_cnt_o(cnt2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
      n_chk++;
      if (act !== ex) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, ex);
      end
   endtask

   // monitor: compare every record due this cycle
   always @(negedge clk) begin
      exp_t e;
      int   s;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         s = e.sel;
         if (e.cyc != cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: record due cycle %0d seen at cycle %0d", e.tag, e.cyc, cyc);
         end else begin
            chk({e.tag, ".valid"},    32'(ov[s]),   32'(e.v));
            chk({e.tag, ".redirect"}, 32'(ordr[s]), 32'(e.r));
            chk({e.tag, ".link_we"},  32'(olwe[s]), 32'(e.lwe));
            chk({e.tag, ".in_ds"},    32'(ods[s]),  32'(e.ds));
            chk({e.tag, ".err"},      32'(oerr[s]), 32'(e.err));
            chk({e.tag, ".cnt"},      32'(ocnt[s]), 32'(e.cnt));
            if (e.dchk) begin
               chk({e.tag, ".target"},    otgt[s],          e.tgt);
               chk({e.tag, ".link_reg"},  32'(olreg[s]),    32'(e.lreg));
               chk({e.tag, ".link_data"}, oldata[s],        e.ldata);
            end
         end
      end
   end

   function automatic stim_t mk_s(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [15:0] imm, input logic [25:0] idx,
                                  input logic [31:0] pc, input logic [31:0] rs,
                                  input logic [31:0] rtd);
      stim_t s;
      s.v = 1'b1; s.st = 1'b0; s.fl = 1'b0;
      s.op = op; s.fn = fn; s.rt = rt; s.rd = rd; s.imm = imm; s.idx = idx;
      s.pc = pc; s.rs = rs; s.rtd = rtd;
      return s;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = mk_s(6'd0, 6'd0, 5'd0, 5'd0, 16'd0, 26'd0, 32'd0, 32'd0, 32'd0);
      s.v = 1'b0;
      return s;
   endfunction

   function automatic stim_t add(input logic [31:0] pc);
      return mk_s(6'd0, 6'h20, 5'd2, 5'd3, 16'd0, 26'd0, pc, 32'd1, 32'd2);
   endfunction

   function automatic stim_t stl(input stim_t s);
      s.st = 1'b1;
      return s;
   endfunction

   function automatic stim_t fls(input stim_t s);
      s.fl = 1'b1;
      return s;
   endfunction

   function automatic exp_t mk_e(input string tag, input logic v, input logic r,
                                 input logic lwe, input logic ds, input logic err,
                                 input logic dchk, input logic [31:0] tgt,
                                 input logic [4:0] lreg, input logic [31:0] ldata,
                                 input logic [15:0] cnt);
      exp_t e;
      e.sel = 0; e.cyc = 0; e.tag = tag;
      e.v = v; e.r = r; e.lwe = lwe; e.ds = ds; e.err = err; e.dchk = dchk;
      e.tgt = tgt; e.lreg = lreg; e.ldata = ldata; e.cnt = cnt;
      return e;
   endfunction

   function automatic exp_t nodata(input string tag, input logic v, input logic ds,
                                   input logic err, input logic [15:0] cnt);
      return mk_e(tag, v, 1'b0, 1'b0, ds, err, 1'b0, 32'd0, 5'd0, 32'd0, cnt);
   endfunction

   task automatic go(input int sel, input stim_t s, input exp_t e);
      for (int i = 0; i < 3; i++) cur[i] = idle();
      cur[sel] = s;
      e.sel = sel;
      e.cyc = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t j20;
      for (int i = 0; i < 3; i++) cur[i] = idle();
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e = mk_e("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 5'd0, 32'd0, 16'd0);
         e.sel = i;
         e.cyc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;

      // delay slot enabled, 16-bit counter
      go(0, mk_s(6'h04, 6'd0, 5'd0, 5'd0, 16'h0003, 26'd0, 32'h100, 32'd5, 32'd5),
         mk_e("beq", 1, 1, 0, 0, 0, 1, 32'h110, 5'd0, 32'h108, 16'd0));
      go(0, add(32'h104), nodata("add_ds_a", 1, 1, 0, 16'd1));
      go(0, mk_s(6'h01, 6'd0, 5'h10, 5'd0, 16'h0010, 26'd0, 32'h200, 32'h1, 32'd0),
         mk_e("bltzal_nt", 1, 0, 1, 0, 0, 1, 32'h244, 5'd31, 32'h208, 16'd1));
      go(0, add(32'h204), nodata("add_ds_b", 1, 1, 0, 16'd1));
      go(0, mk_s(6'd0, 6'h09, 5'd0, 5'd0, 16'd0, 26'd0, 32'h300, 32'h4000, 32'd0),
         mk_e("jalr_rd0", 1, 1, 0, 0, 0, 1, 32'h4000, 5'd0, 32'h308, 16'd1));
      go(0, add(32'h304), nodata("add_ds_c", 1, 1, 0, 16'd2));
      go(0, mk_s(6'd0, 6'h09, 5'd0, 5'd5, 16'd0, 26'd0, 32'h310, 32'h4000, 32'd0),
         mk_e("jalr_rd5", 1, 1, 1, 0, 0, 1, 32'h4000, 5'd5, 32'h318, 16'd2));
      go(0, add(32'h314), nodata("add_ds_d", 1, 1, 0, 16'd3));
      go(0, mk_s(6'h02, 6'd0, 5'd0, 5'd0, 16'd0, 26'h100, 32'h10000400, 32'd0, 32'd0),
         mk_e("j_hi", 1, 1, 0, 0, 0, 1, 32'h10000400, 5'd0, 32'h10000408, 16'd3));
      go(0, mk_s(6'h05, 6'd0, 5'd0, 5'd0, 16'h0004, 26'd0, 32'h10000404, 32'd1, 32'd2),
         nodata("bne_in_slot", 1, 1, 1, 16'd4));
      go(0, mk_s(6'h05, 6'd0, 5'd0, 5'd0, 16'hFFFF, 26'd0, 32'h500, 32'd1, 32'd2),
         mk_e("bne_neg", 1, 1, 0, 0, 0, 1, 32'h500, 5'd0, 32'h508, 16'd4));
      go(0, add(32'h504), nodata("add_ds_e", 1, 1, 0, 16'd5));
      go(0, mk_s(6'h07, 6'd0, 5'd0, 5'd0, 16'h0002, 26'd0, 32'h600, 32'd7, 32'd0),
         mk_e("bgtz", 1, 1, 0, 0, 0, 1, 32'h60C, 5'd0, 32'h608, 16'd5));
      for (int i = 0; i < 3; i++)
         go(0, stl(add(32'h604)), mk_e("stall_hold", 1, 1, 0, 0, 0, 1, 32'h60C, 5'd0, 32'h608, 16'd5));
      go(0, add(32'h604), nodata("unstall_ds", 1, 1, 0, 16'd6));
      go(0, mk_s(6'h06, 6'd0, 5'd0, 5'd0, 16'h0001, 26'd0, 32'h700, 32'd0, 32'd0),
         mk_e("blez_zero", 1, 1, 0, 0, 0, 1, 32'h708, 5'd0, 32'h708, 16'd6));
      go(0, fls(stl(add(32'h704))), nodata("flush_stall", 0, 0, 0, 16'd6));
      go(0, add(32'h800), nodata("post_flush", 1, 0, 0, 16'd6));
      go(0, mk_s(6'h01, 6'd0, 5'h01, 5'd0, 16'h0000, 26'd0, 32'h900, 32'h80000000, 32'd0),
         mk_e("bgez_nt", 1, 0, 0, 0, 0, 1, 32'h904, 5'd0, 32'h908, 16'd6));
      go(0, fls(mk_s(6'h02, 6'd0, 5'd0, 5'd0, 16'd0, 26'h1, 32'h904, 32'd0, 32'd0)),
         nodata("flush_j", 0, 0, 0, 16'd6));
      go(0, mk_s(6'h01, 6'd0, 5'h00, 5'd0, 16'h8000, 26'd0, 32'hA00, 32'hFFFFFFFF, 32'd0),
         mk_e("bltz_minoff", 1, 1, 0, 0, 0, 1, 32'hFFFE0A04, 5'd0, 32'hA08, 16'd6));
      go(0, idle(), nodata("idle_a", 0, 0, 0, 16'd7));
      go(0, add(32'hA04), nodata("add_ds_f", 1, 1, 0, 16'd7));
      go(0, mk_s(6'h03, 6'd0, 5'd0, 5'd0, 16'd0, 26'h3FFFFFF, 32'hF0000000, 32'd0, 32'd0),
         mk_e("jal", 1, 1, 1, 0, 0, 1, 32'hFFFFFFFC, 5'd31, 32'hF0000008, 16'd7));
      go(0, add(32'hF0000004), nodata("add_ds_g", 1, 1, 0, 16'd8));
      go(0, idle(), nodata("idle_b", 0, 0, 0, 16'd8));

      // delay slot disabled
      go(1, mk_s(6'h02, 6'd0, 5'd0, 5'd0, 16'd0, 26'h40, 32'h100, 32'd0, 32'd0),
         mk_e("nd_j", 1, 1, 0, 0, 0, 1, 32'h100, 5'd0, 32'h108, 16'd0));
      go(1, mk_s(6'h05, 6'd0, 5'd0, 5'd0, 16'h0002, 26'd0, 32'h104, 32'd1, 32'd2),
         mk_e("nd_bne", 1, 1, 0, 0, 0, 1, 32'h110, 5'd0, 32'h10C, 16'd1));
      go(1, idle(), nodata("nd_idle", 0, 0, 0, 16'd2));

      // 2-bit counter saturation, then reset mid-sequence
      j20 = mk_s(6'h02, 6'd0, 5'd0, 5'd0, 16'd0, 26'h1, 32'h20, 32'd0, 32'd0);
      for (int i = 0; i < 5; i++)
         go(2, j20, mk_e("c2_j", 1, 1, 0, 0, 0, 1, 32'h4, 5'd0, 32'h28, 16'((i > 3) ? 3 : i)));
      go(2, idle(), nodata("c2_sat", 0, 0, 0, 16'd3));
      go(2, j20, mk_e("c2_j", 1, 1, 0, 0, 0, 1, 32'h4, 5'd0, 32'h28, 16'd3));
      rst = 1'b0;
      go(2, j20, mk_e("c2_rst", 0, 0, 0, 0, 0, 1, 32'd0, 5'd0, 32'd0, 16'd0));
      rst = 1'b1;
      go(2, j20, mk_e("c2_after_rst", 1, 1, 0, 0, 0, 1, 32'h4, 5'd0, 32'h28, 16'd0));
      go(2, idle(), nodata("c2_idle", 0, 0, 0, 16'd1));

      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d records left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
